mem_port_arbiter: RTL and testbench

//  Shares the core's single memory port between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and load/store,
//            LS priority with an IF starvation guard, one transaction in flight.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int STARVE_MAX = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    input  logic                    if_kill,
    output logic                    if_resp_valid,
    output logic [INST_WIDTH-1:0]   if_resp_data,
    input  logic                    ls_req_valid,
    input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
    input  logic                    ls_req_wen,
    input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_req_wmask,
    output logic                    ls_req_ready,
    output logic                    ls_resp_valid,
    output logic [DATA_WIDTH-1:0]   ls_resp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_wen,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_issue_if = 3'd1;
    localparam logic [2:0] c_st_issue_ls = 3'd2;
    localparam logic [2:0] c_st_wait_if  = 3'd3;
    localparam logic [2:0] c_st_wait_ls  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [SW-1:0] r_starve_cnt;
    logic [SW-1:0] w_starve_next;
    logic          r_killed;
    logic          w_killed_next;
    logic          r_if_addr2;

    logic w_if_cand;
    logic w_issue_if;
    logic w_issue_ls;
    logic w_wait_if;
    logic w_wait_ls;

    // A fetch being flushed in the same cycle is not worth arbitrating for.
    assign w_if_cand = if_req_valid && !if_kill;

    always_comb begin
        w_next_state  = r_state;
        w_starve_next = r_starve_cnt;
        w_killed_next = r_killed;
        case (r_state)
            c_st_idle: begin
                if (ls_req_valid && w_if_cand) begin
                    if (r_starve_cnt >= c_starve_max) begin
                        w_next_state  = c_st_issue_if;
                        w_starve_next = '0;
                        w_killed_next = 1'b0;
                    end else begin
                        w_next_state  = c_st_issue_ls;
                        w_starve_next = r_starve_cnt + 1'b1;
                    end
                end else if (ls_req_valid) begin
                    w_next_state = c_st_issue_ls;
                end else if (w_if_cand) begin
                    w_next_state  = c_st_issue_if;
                    w_starve_next = '0;
                    w_killed_next = 1'b0;
                end
            end
            c_st_issue_if: begin
                if (if_kill) w_killed_next = 1'b1;
                if (mem_req_ready) w_next_state = c_st_wait_if;
            end
            c_st_issue_ls: begin
                if (mem_req_ready) w_next_state = c_st_wait_ls;
            end
            c_st_wait_if: begin
                if (if_kill) w_killed_next = 1'b1;
                if (mem_resp_valid) w_next_state = c_st_idle;
            end
            c_st_wait_ls: begin
                if (mem_resp_valid) w_next_state = c_st_idle;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_starve_cnt <= '0;
            r_killed     <= 1'b0;
            r_if_addr2   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_starve_next;
            r_killed     <= w_killed_next;
            if (w_issue_if && mem_req_ready) r_if_addr2 <= if_req_addr[2];
        end
    end

    // Outputs are masked while rst is high so a response landing in the
    // reset cycle never reaches a front end.
    assign w_issue_if = !rst && (r_state == c_st_issue_if);
    assign w_issue_ls = !rst && (r_state == c_st_issue_ls);
    assign w_wait_if  = !rst && (r_state == c_st_wait_if);
    assign w_wait_ls  = !rst && (r_state == c_st_wait_ls);

    assign mem_req_valid = w_issue_if || w_issue_ls;
    assign if_req_ready  = w_issue_if && mem_req_ready;
    assign ls_req_ready  = w_issue_ls && mem_req_ready;

    assign mem_req_addr  = w_issue_ls ? ls_req_addr :
                           (w_issue_if ? if_req_addr : '0);
    assign mem_req_wen   = w_issue_ls && ls_req_wen;
    assign mem_req_wdata = (w_issue_ls && ls_req_wen) ? ls_req_wdata : '0;
    assign mem_req_wmask = (w_issue_ls && ls_req_wen) ? ls_req_wmask : '0;

    assign if_resp_valid = w_wait_if && mem_resp_valid && !r_killed && !if_kill;
    assign ls_resp_valid = w_wait_ls && mem_resp_valid;

    assign if_resp_data  = r_if_addr2 ? mem_resp_data[2*INST_WIDTH-1:INST_WIDTH]
                                      : mem_resp_data[INST_WIDTH-1:0];
    assign ls_resp_data  = mem_resp_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [63:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_kill = 1'b0;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        ls_req_valid = 1'b0;
    logic [63:0] ls_req_addr = '0;
    logic        ls_req_wen = 1'b0;
    logic [63:0] ls_req_wdata = '0;
    logic [7:0]  ls_req_wmask = '0;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .INST_WIDTH(32), .STARVE_MAX(2)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_kill(if_kill), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled 1 time unit later, well away from either edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        repeat (2) begin
            next_cycle();
            #1;
            vectors++;
            if ({mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b want 00000",
                         {mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid});
            end
            vectors++;
            if (mem_req_addr !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_addr: got %h want 0", mem_req_addr);
            end
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: mem_req_valid got %b want 0", mem_req_valid);
        end
    endtask

    task automatic test_if_fetch();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_8000_0004;
        mem_req_ready = 1'b1;
        #1;
        vectors++;
        if (if_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL if_ready_idle: got %b want 0", if_req_ready);
        end
        next_cycle();
        #1;
        vectors++;
        if ({mem_req_valid, if_req_ready, mem_req_wen} !== 3'b110) begin
            miscompares++;
            $display("FAIL if_issue: valid/ready/wen got %b want 110", {mem_req_valid, if_req_ready, mem_req_wen});
        end
        vectors++;
        if (mem_req_addr !== 64'h0000_0000_8000_0004) begin
            miscompares++;
            $display("FAIL if_addr: got %h want 0000000080000004", mem_req_addr);
        end
        next_cycle();
        if_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'h0000_0013_0010_0073;
        #1;
        vectors++;
        if ({if_resp_valid, ls_resp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL if_resp_valid: if/ls got %b want 10", {if_resp_valid, ls_resp_valid});
        end
        vectors++;
        if (if_resp_data !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL if_resp_data: got %h want 00000013", if_resp_data);
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (if_resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL if_resp_pulse: got %b want 0", if_resp_valid);
        end
    endtask

    task automatic test_arbitration();
        bit exp_ls [6];
        bit got_ls [6];
        int grants = 0;
        int cyc = 0;
        int n_ls = 0;
        int n_if = 0;
        bit pending = 1'b0;
        exp_ls[0] = 1'b1; exp_ls[1] = 1'b1; exp_ls[2] = 1'b0;
        exp_ls[3] = 1'b1; exp_ls[4] = 1'b1; exp_ls[5] = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_8000_0010;
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b0;
        ls_req_addr  = 64'h0000_0000_8000_2000;
        mem_req_ready = 1'b1;
        while (grants < 6 && cyc < 60) begin
            next_cycle();
            mem_resp_valid = pending;
            mem_resp_data  = 64'h0123_4567_89AB_CDEF;
            #1;
            pending = 1'b0;
            if (ls_resp_valid) n_ls++;
            if (if_resp_valid) n_if++;
            if (mem_req_valid && mem_req_ready) begin
                got_ls[grants] = ls_req_ready;
                grants++;
                pending = 1'b1;
            end
            cyc++;
        end
        vectors++;
        if (grants != 6) begin
            miscompares++;
            $display("FAIL arb_timeout: grants got %0d want 6", grants);
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (got_ls[i] !== exp_ls[i]) begin
                    miscompares++;
                    $display("FAIL arb_order[%0d]: ls_granted got %b want %b", i, got_ls[i], exp_ls[i]);
                end
            end
        end
        vectors++;
        if (n_ls != 4 || n_if != 1) begin
            miscompares++;
            $display("FAIL arb_resp_count: ls/if got %0d/%0d want 4/1", n_ls, n_if);
        end
        next_cycle();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        mem_resp_valid = pending;
        #1;
        vectors++;
        if ({if_resp_valid, ls_resp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL arb_last_resp: if/ls got %b want 10", {if_resp_valid, ls_resp_valid});
        end
        next_cycle();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_store();
        int pulses = 0;
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b1;
        ls_req_addr  = 64'h0000_0000_8000_1000;
        ls_req_wdata = 64'h1122_3344_5566_7788;
        ls_req_wmask = 8'h0F;
        mem_req_ready = 1'b1;
        next_cycle();
        #1;
        vectors++;
        if ({mem_req_valid, ls_req_ready, mem_req_wen} !== 3'b111) begin
            miscompares++;
            $display("FAIL st_issue: valid/ready/wen got %b want 111", {mem_req_valid, ls_req_ready, mem_req_wen});
        end
        vectors++;
        if (mem_req_addr !== 64'h0000_0000_8000_1000 || mem_req_wdata !== 64'h1122_3344_5566_7788) begin
            miscompares++;
            $display("FAIL st_payload: addr %h data %h want 0000000080001000 1122334455667788", mem_req_addr, mem_req_wdata);
        end
        vectors++;
        if (mem_req_wmask !== 8'h0F) begin
            miscompares++;
            $display("FAIL st_mask: got %h want 0f", mem_req_wmask);
        end
        next_cycle();
        ls_req_valid = 1'b0;
        ls_req_wen   = 1'b0;
        #1;
        if (ls_resp_valid) pulses++;
        vectors++;
        if (mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL st_wait_quiet: mem_req_valid got %b want 0", mem_req_valid);
        end
        next_cycle();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_0000_0001;
        #1;
        if (ls_resp_valid) pulses++;
        vectors++;
        if (if_resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL st_no_if_resp: got %b want 0", if_resp_valid);
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        #1;
        if (ls_resp_valid) pulses++;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL st_resp_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_backpressure();
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b0;
        ls_req_addr  = 64'h0000_0000_8000_2008;
        mem_req_ready = 1'b0;
        next_cycle();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_8000_0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (mem_req_addr !== 64'h0000_0000_8000_2008 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: addr %h if_rdy %b ls_rdy %b want 0000000080002008 0 0",
                         i, mem_req_addr, if_req_ready, ls_req_ready);
            end
            next_cycle();
        end
        mem_req_ready = 1'b1;
        #1;
        vectors++;
        if ({ls_req_ready, if_req_ready, mem_req_wmask} !== 10'b10_0000_0000) begin
            miscompares++;
            $display("FAIL bp_accept: ls_rdy %b if_rdy %b mask %h want 1 0 00", ls_req_ready, if_req_ready, mem_req_wmask);
        end
        next_cycle();
        ls_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hAAAA_AAAA_BBBB_BBBB;
        #1;
        vectors++;
        if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'hAAAA_AAAA_BBBB_BBBB) begin
            miscompares++;
            $display("FAIL bp_ls_resp: valid %b data %h want 1 aaaaaaaabbbbbbbb", ls_resp_valid, ls_resp_data);
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        next_cycle();
        #1;
        vectors++;
        if (mem_req_valid !== 1'b1 || if_req_ready !== 1'b1 || mem_req_addr !== 64'h0000_0000_8000_0100) begin
            miscompares++;
            $display("FAIL bp_if_issue: valid %b rdy %b addr %h want 1 1 0000000080000100", mem_req_valid, if_req_ready, mem_req_addr);
        end
        next_cycle();
        if_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        vectors++;
        if (if_resp_valid !== 1'b1 || if_resp_data !== 32'hBBBB_BBBB) begin
            miscompares++;
            $display("FAIL bp_if_resp: valid %b data %h want 1 bbbbbbbb", if_resp_valid, if_resp_data);
        end
        next_cycle();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_kill();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_8000_0200;
        mem_req_ready = 1'b1;
        next_cycle();
        #1;
        vectors++;
        if (if_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_if_issue: if_req_ready got %b want 1", if_req_ready);
        end
        next_cycle();
        if_req_valid = 1'b0;
        if_kill      = 1'b1;
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b0;
        ls_req_addr  = 64'h0000_0000_8000_3000;
        next_cycle();
        if_kill = 1'b0;
        next_cycle();
        mem_resp_valid = 1'b1;
        #1;
        vectors++;
        if ({if_resp_valid, ls_resp_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL kill_suppress: if/ls got %b want 00", {if_resp_valid, ls_resp_valid});
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (mem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_idle: mem_req_valid got %b want 0", mem_req_valid);
        end
        next_cycle();
        #1;
        vectors++;
        if (ls_req_ready !== 1'b1 || mem_req_addr !== 64'h0000_0000_8000_3000) begin
            miscompares++;
            $display("FAIL kill_ls_next: rdy %b addr %h want 1 0000000080003000", ls_req_ready, mem_req_addr);
        end
        next_cycle();
        ls_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        vectors++;
        if (ls_resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_ls_resp: got %b want 1", ls_resp_valid);
        end
        next_cycle();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        if_req_valid = 1'b1;
        if_req_addr  = 64'h0000_0000_8000_0300;
        ls_req_valid = 1'b1;
        ls_req_wen   = 1'b0;
        ls_req_addr  = 64'h0000_0000_8000_4000;
        mem_req_ready = 1'b1;
        next_cycle();
        #1;
        vectors++;
        if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_ls_grant: ls_rdy %b if_rdy %b want 1 0", ls_req_ready, if_req_ready);
        end
        next_cycle();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        #1;
        vectors++;
        if (dut.r_starve_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL rw_starve_pre: got %0d want 1", dut.r_starve_cnt);
        end
        vectors++;
        if ({mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL rw_outputs: got %b want 00000",
                     {mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid});
        end
        next_cycle();
        mem_resp_valid = 1'b0;
        #1;
        vectors++;
        if (dut.r_starve_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL rw_starve_post: got %0d want 0", dut.r_starve_cnt);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({mem_req_valid, ls_resp_valid, mem_req_addr} !== 66'b0) begin
            miscompares++;
            $display("FAIL rw_idle: valid %b resp %b addr %h want 0 0 0", mem_req_valid, ls_resp_valid, mem_req_addr);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_arbitration();
        test_store();
        test_backpressure();
        test_kill();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
